brick_fall_engine: RTL and testbench
====================================

Name: brick_fall_engine

Overview:
- Game-state stage feeding the paddle/column selector: owns the falling brick's row and the stack height of the three columns (left/centre/right).
- Consumes the selector's `col` output and produces `row`, `hauteurGauche`, `hauteurCentre` and `hauteurDroite`, which the selector uses to gate sideways moves.
- Lowers the brick one row per fall tick, lands it on the stack, clears a full layer, respawns the brick at the top, and detects game over.

Parameters:
- TICK_DIV, 25000000, clock cycles per fall step; minimum 2.
- TOP_ROW, 7, spawn row; fixed by the 3-bit row encoding.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- col  input  2  current brick column from the selector: 0=left, 1=centre, 2=right; 3 is treated as 1.
- enable  input  1  when low, the tick counter and FSM hold (pause).
- row  output  3  falling brick row; 0 = floor.
- hauteurGauche  output  3  left stack height.
- hauteurCentre  output  3  centre stack height.
- hauteurDroite  output  3  right stack height.
- score  output  8  layers cleared, wraps modulo 256.
- landed  output  1  one-cycle pulse in the LAND state.
- cleared  output  1  one-cycle pulse when a layer is removed.
- game_over  output  1  level; held until reset.

Behaviour:
- Reset values: row=TOP_ROW; all heights=0; score=0; landed=0; cleared=0; game_over=0; state=FALL; tick counter=0. Reset has priority over everything, including in the OVER state.
- Tick counter:
  - Counts 0..TICK_DIV-1 in FALL only, and only while enable=1.
  - Tick = counter at terminal count; the counter wraps to 0 on that cycle.
  - Counter is cleared in SPAWN.
- h(c) means the height register of column c; `col` is sampled on the tick cycle.
- FALL, on tick:
  - If row <= h(col): latch col into land_col and go to LAND. Row is not changed.
  - Otherwise row <= row-1.
  - The brick therefore rests visibly at row==h for one full tick period, during which sideways moves are still honoured.
- LAND (1 cycle):
  - landed=1.
  - If row==TOP_ROW: go to OVER; the height is NOT incremented (no 3-bit overflow).
  - Else h(land_col) <= h(land_col)+1, then go to CLEAR.
- CLEAR (1 cycle):
  - Uses the heights updated in LAND.
  - If all three heights >= 1: every height decrements by 1, score+1 (wrapping), cleared=1.
  - Then go to SPAWN.
- SPAWN (1 cycle): row <= TOP_ROW, tick counter <= 0, go to FALL.
- OVER: game_over=1; row and heights frozen; tick, col and enable are ignored until reset.
- Latency from tick edge T (the edge that moves the FSM to LAND):
  - landed high in cycle T..T+1.
  - New height visible after edge T+1; cleared high and cleared heights/score visible after edge T+2 (same cycle).
  - row=TOP_ROW visible after edge T+3; FALL resumes at T+3.
- enable=0 in LAND/CLEAR/SPAWN: the FSM holds its state and the pulse repeats; no register changes.
- All outputs are registered; no combinational path from col to any output.

Test Plan (TICK_DIV=4 unless noted):
- Reset, col=1, enable=1 -> row steps 7,6,…,0 every 4 cycles. Next tick at row 0 -> landed pulse; hauteurCentre=1 three edges later... precisely after edge T+1; row=7 after edge T+3; score=0.
- Land one brick each at col=0, 1 and 2 -> after the third LAND: heights briefly 1/1/1, then the CLEAR cycle gives 0/0/0, cleared=1 for exactly one cycle, score=1.
- Seven bricks at col=1 -> hauteurCentre=7. Eighth brick lands at row 7 -> game_over=1, hauteurCentre stays 7, row stays 7. 100 further cycles with col changes -> no output changes.
- Preload hauteurGauche=2 via 2 landings at col 0. Centre brick falls; switch col to 0 while row=3 -> brick lands at row 2, hauteurGauche becomes 3, hauteurCentre unchanged.
- Assert reset during the LAND cycle and again while in OVER -> the next edge gives all reset values; the falling sequence restarts from row 7.
- col=3 throughout a fall -> lands on centre (hauteurCentre increments). enable=0 for 10 cycles mid-fall -> row and counter frozen, then resume with exact remaining tick spacing.

Source files
------------

// File: rtl/brick_fall_engine.sv
// Falling-brick game state: brick row, three column stack heights, layer clear,
// respawn and game-over detection, stepped by a divided fall tick.
module brick_fall_engine #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned TOP_ROW  = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] col,
    input  logic       enable,
    output logic [2:0] row,
    output logic [2:0] hauteurGauche,
    output logic [2:0] hauteurCentre,
    output logic [2:0] hauteurDroite,
    output logic [7:0] score,
    output logic       landed,
    output logic       cleared,
    output logic       game_over
);

    localparam int unsigned     CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]      TOP     = 3'(TOP_ROW);

    typedef enum logic [2:0] {
        S_FALL,
        S_LAND,
        S_CLEAR,
        S_SPAWN,
        S_OVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       row_q, row_d;
    logic [2:0]       hl_q, hl_d, hc_q, hc_d, hr_q, hr_d;
    logic [1:0]       land_col_q, land_col_d;
    logic [7:0]       score_q, score_d;
    logic             landed_q, landed_d;
    logic             cleared_q, cleared_d;
    logic             over_q, over_d;

    logic [1:0]       col_n;
    logic [2:0]       h_sel;

    // Column code 3 behaves as centre.
    always_comb begin
        col_n = (col == 2'd3) ? 2'd1 : col;
        case (col_n)
            2'd0:    h_sel = hl_q;
            2'd2:    h_sel = hr_q;
            default: h_sel = hc_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        hl_d       = hl_q;
        hc_d       = hc_q;
        hr_d       = hr_q;
        land_col_d = land_col_q;
        score_d    = score_q;
        over_d     = over_q;
        landed_d   = 1'b0;
        cleared_d  = 1'b0;

        if (enable) begin
            case (state_q)
                S_FALL: begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_d = '0;
                        if (row_q <= h_sel) begin
                            land_col_d = col_n;
                            landed_d   = 1'b1;
                            state_d    = S_LAND;
                        end else begin
                            row_d = row_q - 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A brick stopping at the spawn row ends the game before any height can overflow.
                S_LAND: begin
                    if (row_q == TOP) begin
                        over_d  = 1'b1;
                        state_d = S_OVER;
                    end else begin
                        case (land_col_q)
                            2'd0:    hl_d = hl_q + 3'd1;
                            2'd2:    hr_d = hr_q + 3'd1;
                            default: hc_d = hc_q + 3'd1;
                        endcase
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if ((hl_q != 3'd0) && (hc_q != 3'd0) && (hr_q != 3'd0)) begin
                        hl_d      = hl_q - 3'd1;
                        hc_d      = hc_q - 3'd1;
                        hr_d      = hr_q - 3'd1;
                        score_d   = score_q + 8'd1;
                        cleared_d = 1'b1;
                    end
                    state_d = S_SPAWN;
                end
                S_SPAWN: begin
                    row_d   = TOP;
                    cnt_d   = '0;
                    state_d = S_FALL;
                end
                default: ;
            endcase
        end else begin
            // Paused: the current pulse is held along with everything else.
            landed_d  = landed_q;
            cleared_d = cleared_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FALL;
            cnt_q      <= '0;
            row_q      <= TOP;
            hl_q       <= 3'd0;
            hc_q       <= 3'd0;
            hr_q       <= 3'd0;
            land_col_q <= 2'd1;
            score_q    <= 8'd0;
            landed_q   <= 1'b0;
            cleared_q  <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            hl_q       <= hl_d;
            hc_q       <= hc_d;
            hr_q       <= hr_d;
            land_col_q <= land_col_d;
            score_q    <= score_d;
            landed_q   <= landed_d;
            cleared_q  <= cleared_d;
            over_q     <= over_d;
        end
    end

    assign row           = row_q;
    assign hauteurGauche = hl_q;
    assign hauteurCentre = hc_q;
    assign hauteurDroite = hr_q;
    assign score         = score_q;
    assign landed        = landed_q;
    assign cleared       = cleared_q;
    assign game_over     = over_q;

endmodule

// File: tb/tb_brick_fall_engine.sv
// Scoreboarded bench for brick_fall_engine with a 4-cycle fall tick.
module tb_brick_fall_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] col;
    logic       enable;
    logic [2:0] row, hl, hc, hr;
    logic [7:0] score;
    logic       landed, cleared, game_over;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b1;

    typedef struct packed {
        logic [2:0] lrow;
        logic [2:0] hl, hc, hr;
        logic       over;
        logic [2:0] cl, cc, cr;
        logic [7:0] sc;
        logic       clr;
    } exp_t;

    exp_t exp_q[$];

    brick_fall_engine #(.TICK_DIV(4), .TOP_ROW(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .col           (col),
        .enable        (enable),
        .row           (row),
        .hauteurGauche (hl),
        .hauteurCentre (hc),
        .hauteurDroite (hr),
        .score         (score),
        .landed        (landed),
        .cleared       (cleared),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] lrow, input logic [2:0] a, b, c, input logic over,
                        input logic [2:0] x, y, z, input logic [7:0] sc, input logic clr);
        exp_t e;
        e = '{lrow: lrow, hl: a, hc: b, hr: c, over: over, cl: x, cc: y, cr: z, sc: sc, clr: clr};
        exp_q.push_back(e);
    endtask

    task automatic wait_land();
        bit seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (landed) begin
                seen = 1'b1;
                break;
            end
        end
        chk("land_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_row(input logic [2:0] r);
        bit seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (row == r) begin
                seen = 1'b1;
                break;
            end
        end
        chk("row_reached", 32'(seen), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row"}, 32'(row), 32'd7);
        chk({tag, "_heights"}, 32'({hl, hc, hr}), 32'd0);
        chk({tag, "_score"}, 32'(score), 32'd0);
        chk({tag, "_flags"}, 32'({landed, cleared, game_over}), 32'd0);
    endtask

    // Monitor: each landing pulse pops one expectation and follows the land/clear/spawn sequence.
    initial begin
        exp_t e;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && landed && !prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_land", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("land_row", 32'(row), 32'(e.lrow));
                    @(negedge clk);
                    chk("land_heights", 32'({hl, hc, hr}), 32'({e.hl, e.hc, e.hr}));
                    chk("land_over", 32'(game_over), 32'(e.over));
                    chk("landed_one_cycle", 32'(landed), 32'd0);
                    if (!e.over) begin
                        @(negedge clk);
                        chk("clear_flag", 32'(cleared), 32'(e.clr));
                        chk("clear_heights", 32'({hl, hc, hr}), 32'({e.cl, e.cc, e.cr}));
                        chk("clear_score", 32'(score), 32'(e.sc));
                        @(negedge clk);
                        chk("spawn_row", 32'(row), 32'd7);
                        chk("cleared_one_cycle", 32'(cleared), 32'd0);
                    end
                end
            end
            prev = landed;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        col    = 2'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // First brick at centre, verifying the tick spacing of every row step.
        push(3'd0, 3'd0, 3'd1, 3'd0, 1'b0, 3'd0, 3'd1, 3'd0, 8'd0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            repeat (3) @(negedge clk);
            chk("row_hold", 32'(row), 32'(8 - i));
            @(negedge clk);
            chk("row_step", 32'(row), 32'(7 - i));
        end
        wait_land();

        // Fill left and right to complete a layer.
        col = 2'd0;
        push(3'd0, 3'd1, 3'd1, 3'd0, 1'b0, 3'd1, 3'd1, 3'd0, 8'd0, 1'b0);
        wait_land();
        col = 2'd2;
        push(3'd0, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 3'd0, 3'd0, 8'd1, 1'b1);
        wait_land();

        // Preload left to 2, then steer a centre brick left at row 3.
        col = 2'd0;
        push(3'd0, 3'd1, 3'd0, 3'd0, 1'b0, 3'd1, 3'd0, 3'd0, 8'd1, 1'b0);
        wait_land();
        push(3'd1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd2, 3'd0, 3'd0, 8'd1, 1'b0);
        wait_land();
        col = 2'd1;
        push(3'd2, 3'd3, 3'd0, 3'd0, 1'b0, 3'd3, 3'd0, 3'd0, 8'd1, 1'b0);
        wait_row(3'd3);
        col = 2'd0;
        wait_land();

        // col=3 acts as centre; pause mid-fall with one counter step already taken.
        col = 2'd3;
        push(3'd0, 3'd3, 3'd1, 3'd0, 1'b0, 3'd3, 3'd1, 3'd0, 8'd1, 1'b0);
        wait_row(3'd5);
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("pause_row", 32'(row), 32'd5);
        end
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("resume_hold", 32'(row), 32'd5);
        @(negedge clk);
        chk("resume_step", 32'(row), 32'd4);
        wait_land();

        // Reset during the LAND cycle.
        mon_en = 1'b0;
        col    = 2'd1;
        wait_row(3'd1);
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (landed) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("land_before_reset", 32'(seen), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset_in_land");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("restart_hold", 32'(row), 32'd7);
        @(negedge clk);
        chk("restart_step", 32'(row), 32'd6);
        mon_en = 1'b1;

        // Stack the centre column to the top, then the eighth brick ends the game.
        for (int k = 1; k <= 7; k++) begin
            push(3'(k - 1), 3'd0, 3'(k), 3'd0, 1'b0, 3'd0, 3'(k), 3'd0, 8'd0, 1'b0);
            wait_land();
        end
        push(3'd7, 3'd0, 3'd7, 3'd0, 1'b1, 3'd0, 3'd7, 3'd0, 8'd0, 1'b0);
        wait_land();
        for (int i = 0; i < 100; i++) begin
            col    = 2'($urandom_range(0, 3));
            enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("over_frozen", 32'({row, hl, hc, hr, score, landed, cleared, game_over}),
                32'({3'd7, 3'd0, 3'd7, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1}));
        end

        // Reset out of OVER.
        enable = 1'b1;
        col    = 2'd1;
        reset  = 1'b1;
        @(negedge clk);
        chk_reset_vals("reset_in_over");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("over_restart_hold", 32'(row), 32'd7);
        @(negedge clk);
        chk("over_restart_step", 32'(row), 32'd6);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
